ps2_key_ctrl: RTL and testbench
===============================

// Module: ps2_key_ctrl
// PURPOSE
//  Sequencer behind the PS/2 byte receiver. Takes validated scan-code bytes and
//  folds E0/F0 prefixes into single key events {repeat,ext,brk,code}. Queues the
//  events in a small FIFO for a valid/ready consumer (CPU MMIO or display logic).
//  Also tracks the currently held key and a press counter.
// PARAMETERS
//  FIFO_DEPTH  8   event FIFO entries; power of two, >=2
// PORTS
//  clk          in   1   system clock; the only clock
//  resetn       in   1   asynchronous, active-low reset
//  rx_valid     in   1   1-cycle pulse: rx_data holds a byte whose start, stop and parity checks passed
//  rx_data      in   8   received scan-code byte
//  rx_err       in   1   1-cycle pulse: frame failed its checks; never high in the same cycle as rx_valid
//  ev_valid     out  1   FIFO head valid
//  ev_ready     in   1   consumer accepts the head when ev_valid&&ev_ready
//  ev_data      out  11  {repeat,ext,brk,code[7:0]}; defined only while ev_valid=1
//  held_valid   out  1   a key is currently down
//  held_code    out  9   {ext,code} of the last key pressed
//  press_count  out  8   count of non-repeat make events; wraps 0xFF->0x00
//  overflow     out  1   sticky: an event was dropped because the FIFO was full
//  ovf_clr      in   1   synchronous clear of overflow
// BEHAVIOUR
//  Reset (async assert, sync deassert by the upstream reset synchronizer):
//   decoder FSM=IDLE; FIFO empty; all outputs 0.
//  Decoder FSM (advances only on rx_valid):
//   IDLE:   E0->EXT; F0->BRK; else emit(ext=0,brk=0), stay IDLE
//   EXT:    F0->EXTBRK; E0->EXT; else emit(1,0), ->IDLE
//   BRK:    F0->BRK; E0->EXT (prefix restart); else emit(0,1), ->IDLE
//   EXTBRK: E0 or F0->EXTBRK (ignored); else emit(1,1), ->IDLE
//   Bytes 00, FF and E1 in any state: discarded, no event, ->IDLE.
//   rx_err in any state: ->IDLE; partial prefix discarded.
//  Emit rules (same cycle as the final byte):
//   repeat=1 iff brk=0 && held_valid && held_code=={ext,code}.
//   Make, not repeat: held_code<={ext,code}; held_valid<=1; press_count+=1.
//   Break matching held_code: held_valid<=0. Any other break: held state unchanged.
//   press_count and held state update even when the FIFO drops the event.
//  FIFO, registered outputs:
//   A push into an empty FIFO shows ev_valid=1 on the next cycle (latency 1).
//   Pop when ev_valid&&ev_ready; the next entry appears on the next cycle.
//   A push while full with no pop: event dropped; overflow<=1.
//   Simultaneous push and pop while full: both happen; no drop.
//   Simultaneous push and pop while empty: no pop happens; the push occurs.
//   Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from
//   the pointer MSB and LSBs.
//   ev_data is held stable while ev_valid=1 && ev_ready=0.
//  overflow: the set has priority over ovf_clr in the same cycle.
//  Reset mid-sequence (e.g. after E0 only): FSM=IDLE, FIFO emptied; the later
//   final byte is decoded as a plain make.
// STRUCTURE
//  Package ps2_pkg: localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1;
//   FSM state encodings IDLE/EXT/BRK/EXTBRK; EV_W=11 and field offsets.
//  Sub-module ps2_ev_fifo: parameterised sync FIFO (WIDTH, DEPTH), clk/resetn,
//   push/din/full, pop/dout/empty. Decoder and held/counter logic stay in top.
// TESTING
//  1 Bytes 1C, F0, 1C -> events 0x01C then 0x11C; press_count=1; held_valid 1 then 0.
//  2 Bytes E0, 75, E0, F0, 75 -> events 0x275 then 0x375; held_code=0x175 during the press.
//  3 Typematic 1C x3, ev_ready=1 -> 0x01C, 0x41C, 0x41C; press_count=1.
//  4 ev_ready=0, 9 makes with FIFO_DEPTH=8 -> 8 events queued, overflow=1; drain
//    gives the first 8 in order; ovf_clr -> overflow=0.
//  5 FIFO full, new event pushed with ev_ready=1 in the same cycle -> no drop,
//    overflow stays 0, order kept.
//  6 E0, rx_err, 1C -> single event 0x01C; E0 then resetn low for 1 cycle, then
//    1C -> 0x01C, all counters restart from 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key sequencer: prefix bytes, decoder states and
// the packed key-event layout {repeat, ext, brk, code[7:0]}.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam int EV_W        = 11;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;
    localparam int EV_REP_BIT  = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } dec_state_t;

    // Keyboard error/ack/pause bytes that never form a key event.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_ev_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module ps2_ev_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Folds E0/F0 prefixed scan codes into single key events, tracks the held key
// and press count, and queues events for a valid/ready consumer.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    input  logic            rx_err,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [EV_W-1:0] ev_data,
    output logic            held_valid,
    output logic [8:0]      held_code,
    output logic [7:0]      press_count,
    output logic            overflow,
    input  logic            ovf_clr
);

    // Consumer handshake: the head entry transfers on any cycle where
    // ev_valid && ev_ready; ev_data stays stable while ev_valid && !ev_ready.

    dec_state_t      state;
    dec_state_t      state_next;
    logic            emit;
    logic            emit_ext;
    logic            emit_brk;
    logic [8:0]      key;
    logic            is_repeat;
    logic [EV_W-1:0] ev_in;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ev_pop;
    logic            drop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        if (rx_err) begin
            state_next = IDLE;
        end else if (rx_valid) begin
            if (is_discard(rx_data)) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_data == PS2_EXT)      state_next = EXT;
                        else if (rx_data == PS2_BRK) state_next = BRK;
                        else                         emit = 1'b1;
                    end
                    EXT: begin
                        if (rx_data == PS2_BRK)      state_next = EXTBRK;
                        else if (rx_data == PS2_EXT) state_next = EXT;
                        else begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    BRK: begin
                        if (rx_data == PS2_BRK)      state_next = BRK;
                        else if (rx_data == PS2_EXT) state_next = EXT;
                        else begin
                            emit       = 1'b1;
                            emit_brk   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    EXTBRK: begin
                        if (rx_data == PS2_EXT || rx_data == PS2_BRK) begin
                            state_next = EXTBRK;
                        end else begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            emit_brk   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    assign key       = {emit_ext, rx_data};
    assign is_repeat = !emit_brk && held_valid && (held_code == key);

    always_comb begin
        ev_in                        = '0;
        ev_in[EV_CODE_LSB +: 8]      = rx_data;
        ev_in[EV_BRK_BIT]            = emit_brk;
        ev_in[EV_EXT_BIT]            = emit_ext;
        ev_in[EV_REP_BIT]            = is_repeat;
    end

    assign ev_valid = !fifo_empty;
    assign ev_pop   = ev_valid && ev_ready;
    assign drop     = emit && fifo_full && !ev_pop;

    ps2_ev_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (emit),
        .din    (ev_in),
        .full   (fifo_full),
        .pop    (ev_pop),
        .dout   (ev_data),
        .empty  (fifo_empty)
    );

    // Held-key tracking follows every decoded event, even ones the FIFO drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_valid  <= 1'b0;
            held_code   <= '0;
            press_count <= '0;
        end else if (emit) begin
            if (!emit_brk) begin
                if (!is_repeat) begin
                    held_code   <= key;
                    held_valid  <= 1'b1;
                    press_count <= press_count + 8'd1;
                end
            end else if (held_code == key) begin
                held_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed scenarios plus a randomized byte stream
// checked against a prefix-flag reference model of the key decoder and event queue.
module tb_ps2_key_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic        ev_valid;
    logic        ev_ready;
    logic [10:0] ev_data;
    logic        held_valid;
    logic [8:0]  held_code;
    logic [7:0]  press_count;
    logic        overflow;
    logic        ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_ext;
    logic        m_brk;
    logic        m_held_valid;
    logic [8:0]  m_held_code;
    logic [7:0]  m_count;
    logic        m_ovf;
    logic [10:0] m_fifo[$];
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    always #5 clk = ~clk;

    ps2_key_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_err      (rx_err),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_data     (ev_data),
        .held_valid  (held_valid),
        .held_code   (held_code),
        .press_count (press_count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    task automatic model_clear();
        m_ext        = 1'b0;
        m_brk        = 1'b0;
        m_held_valid = 1'b0;
        m_held_code  = '0;
        m_count      = '0;
        m_ovf        = 1'b0;
        m_fifo.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    // Entered and left on a falling edge; resetn low for one full cycle.
    task automatic apply_reset();
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_err   = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // One clock cycle of stimulus; records consumed DUT events and advances the model.
    task automatic step(input logic v, input logic [7:0] b, input logic err,
                        input logic rdy, input logic clr);
        logic        pop_now;
        logic        full_now;
        logic        emit;
        logic        drop;
        logic        rep;
        logic [8:0]  key;
        logic [10:0] ev;
        rx_valid = v;
        rx_data  = b;
        rx_err   = err;
        ev_ready = rdy;
        ovf_clr  = clr;
        #1;
        if (ev_valid && ev_ready) got_q.push_back(ev_data);
        full_now = (m_fifo.size() == DEPTH);
        pop_now  = rdy && (m_fifo.size() != 0);
        emit     = 1'b0;
        drop     = 1'b0;
        ev       = '0;
        if (err) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (v) begin
            if (b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                if (!(m_ext && m_brk)) begin
                    m_ext = 1'b1;
                    m_brk = 1'b0;
                end
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                key  = {m_ext, b};
                rep  = !m_brk && m_held_valid && (m_held_code == key);
                ev   = {rep, m_ext, m_brk, b};
                emit = 1'b1;
                drop = full_now && !pop_now;
                if (!m_brk && !rep) begin
                    m_held_code  = key;
                    m_held_valid = 1'b1;
                    m_count      = m_count + 8'd1;
                end else if (m_brk && m_held_code == key) begin
                    m_held_valid = 1'b0;
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        if (pop_now) exp_q.push_back(m_fifo.pop_front());
        if (emit && !drop) m_fifo.push_back(ev);
        m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        step(1'b1, b, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %0b want 0", ev_valid); end
        n_checks++; if (ev_data !== 11'h000) begin n_fail++; $display("FAIL reset_ev_data: got %h want 000", ev_data); end
        n_checks++; if (held_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_valid: got %0b want 0", held_valid); end
        n_checks++; if (held_code !== 9'h000) begin n_fail++; $display("FAIL reset_held_code: got %h want 000", held_code); end
        n_checks++; if (press_count !== 8'h00) begin n_fail++; $display("FAIL reset_press_count: got %h want 00", press_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_make_break();
        logic [10:0] want[$];
        apply_reset();
        send(8'h1C, 1'b1);
        n_checks++; if (held_valid !== 1'b1) begin n_fail++; $display("FAIL mb_held_on: got %0b want 1", held_valid); end
        n_checks++; if (held_code !== 9'h01C) begin n_fail++; $display("FAIL mb_held_code: got %h want 01c", held_code); end
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        idle(3, 1'b1);
        n_checks++; if (held_valid !== 1'b0) begin n_fail++; $display("FAIL mb_held_off: got %0b want 0", held_valid); end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL mb_press_count: got %0d want 1", press_count); end
        want = '{11'h01C, 11'h11C};
        n_checks++; if (got_q.size() != want.size()) begin n_fail++; $display("FAIL mb_event_count: got %0d want %0d", got_q.size(), want.size()); end
        for (int i = 0; i < want.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin n_fail++; $display("FAIL mb_event[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 11'hxxx, want[i]); end
        end
    endtask

    task automatic test_extended();
        logic [10:0] want[$];
        apply_reset();
        send(8'hE0, 1'b1);
        send(8'h75, 1'b1);
        n_checks++; if (held_code !== 9'h175) begin n_fail++; $display("FAIL ext_held_code: got %h want 175", held_code); end
        n_checks++; if (held_valid !== 1'b1) begin n_fail++; $display("FAIL ext_held_on: got %0b want 1", held_valid); end
        send(8'hE0, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h75, 1'b1);
        idle(3, 1'b1);
        n_checks++; if (held_valid !== 1'b0) begin n_fail++; $display("FAIL ext_held_off: got %0b want 0", held_valid); end
        want = '{11'h275, 11'h375};
        n_checks++; if (got_q.size() != want.size()) begin n_fail++; $display("FAIL ext_event_count: got %0d want %0d", got_q.size(), want.size()); end
        for (int i = 0; i < want.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin n_fail++; $display("FAIL ext_event[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 11'hxxx, want[i]); end
        end
    endtask

    task automatic test_typematic();
        logic [10:0] want[$];
        apply_reset();
        for (int i = 0; i < 3; i++) send(8'h1C, 1'b1);
        idle(3, 1'b1);
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL typ_press_count: got %0d want 1", press_count); end
        want = '{11'h01C, 11'h41C, 11'h41C};
        n_checks++; if (got_q.size() != want.size()) begin n_fail++; $display("FAIL typ_event_count: got %0d want %0d", got_q.size(), want.size()); end
        for (int i = 0; i < want.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== want[i]) begin n_fail++; $display("FAIL typ_event[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 11'hxxx, want[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] code;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            code = 8'h10 + 8'(i);
            send(code, 1'b0);
            n_checks++; if (ev_data !== 11'h010) begin n_fail++; $display("FAIL ovf_head_stable[%0d]: got %h want 010", i, ev_data); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", overflow); end
        n_checks++; if (press_count !== 8'd9) begin n_fail++; $display("FAIL ovf_press_count: got %0d want 9", press_count); end
        idle(10, 1'b1);
        n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL ovf_event_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            code = 8'h10 + 8'(i);
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== {3'b000, code}) begin n_fail++; $display("FAIL ovf_event[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 11'hxxx, {3'b000, code}); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            code = 8'h30 + 8'(i);
            send(code, 1'b0);
        end
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_beats_clr: got %0b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] code;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            code = 8'h10 + 8'(i);
            send(code, 1'b0);
        end
        n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_full_valid: got %0b want 1", ev_valid); end
        send(8'h20, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_no_overflow: got %0b want 0", overflow); end
        idle(10, 1'b1);
        n_checks++; if (got_q.size() != 9) begin n_fail++; $display("FAIL fpp_event_count: got %0d want 9", got_q.size()); end
        for (int i = 0; i < 9; i++) begin
            code = (i < 8) ? 8'h10 + 8'(i) : 8'h20;
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== {3'b000, code}) begin n_fail++; $display("FAIL fpp_event[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 11'hxxx, {3'b000, code}); end
        end
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_drained: got %0b want 0", ev_valid); end
    endtask

    task automatic test_err_reset();
        apply_reset();
        send(8'hE0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        send(8'h1C, 1'b1);
        idle(3, 1'b1);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL err_event_count: got %0d want 1", got_q.size()); end
        n_checks++; if (got_q.size() == 0 || got_q[0] !== 11'h01C) begin n_fail++; $display("FAIL err_event: got %h want 01c", (got_q.size() != 0) ? got_q[0] : 11'hxxx); end
        send(8'h22, 1'b0);
        n_checks++; if (press_count !== 8'd2) begin n_fail++; $display("FAIL err_press_before_reset: got %0d want 2", press_count); end
        send(8'hE0, 1'b0);
        apply_reset();
        n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_emptied: got %0b want 0", ev_valid); end
        n_checks++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL rst_press_count: got %0d want 0", press_count); end
        send(8'h1C, 1'b0);
        n_checks++; if (ev_valid !== 1'b1 || ev_data !== 11'h01C) begin n_fail++; $display("FAIL rst_plain_make: got valid=%0b data=%h want valid=1 data=01c", ev_valid, ev_data); end
        n_checks++; if (press_count !== 8'd1) begin n_fail++; $display("FAIL rst_press_restart: got %0d want 1", press_count); end
        n_checks++; if (held_code !== 9'h01C) begin n_fail++; $display("FAIL rst_held_code: got %h want 01c", held_code); end
        idle(2, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] pool[12];
        logic       v;
        logic       err;
        logic       rdy;
        logic       clr;
        logic [7:0] b;
        pool = '{8'h1C, 8'h75, 8'h22, 8'h5A, 8'h1C, 8'hE0, 8'hE0, 8'hF0,
                 8'hF0, 8'hE1, 8'h00, 8'hFF};
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            v   = ($urandom_range(0, 3) != 0);
            err = !v && ($urandom_range(0, 7) == 0);
            b   = pool[$urandom_range(0, 11)];
            rdy = ($urandom_range(0, 9) < (((k / 100) % 2 == 0) ? 2 : 8));
            clr = ($urandom_range(0, 15) == 0);
            step(v, b, err, rdy, clr);
            n_checks++; if (held_valid !== m_held_valid) begin n_fail++; $display("FAIL rnd_held_valid@%0d: got %0b want %0b", k, held_valid, m_held_valid); end
            n_checks++; if (held_code !== m_held_code) begin n_fail++; $display("FAIL rnd_held_code@%0d: got %h want %h", k, held_code, m_held_code); end
            n_checks++; if (press_count !== m_count) begin n_fail++; $display("FAIL rnd_press_count@%0d: got %0d want %0d", k, press_count, m_count); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %0b want %0b", k, overflow, m_ovf); end
            n_checks++; if (ev_valid !== (m_fifo.size() != 0)) begin n_fail++; $display("FAIL rnd_ev_valid@%0d: got %0b want %0b", k, ev_valid, m_fifo.size() != 0); end
        end
        idle(DEPTH + 4, 1'b1);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_event_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_event[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 11'hxxx, exp_q[i]); end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_err   = 1'b0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        @(negedge clk);
        test_reset();
        test_make_break();
        test_extended();
        test_typematic();
        test_overflow();
        test_full_push_pop();
        test_err_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
